mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates the single main-memory port (mem_main) between two requesters.
- Port A: stage-three data access. Port B: auxiliary requester (instruction fetch / loader).
- Per-cycle arbitration. Port A has fixed priority, and an anti-starvation counter promotes B.
- Read data returns one cycle after grant and is routed back to the owning port; the arbiter also generates the A-side stall.

Parameters:
- AW, 16, address width
- DW, 16, data width
- MAX_WAIT, 4, consecutive denied B cycles before B is forced priority (1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- halt_sys  in  1  global halt; freezes arbitration
- a_req  in  1  port A access request
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  AW  port A address
- a_wdata  in  DW  port A write data
- a_gnt  out  1  port A granted this cycle
- a_stall  out  1  a_req & ~a_gnt; pipeline stall to stage three
- a_rvalid  out  1  port A read data valid
- a_rdata  out  DW  port A read data
- b_req, b_we, b_addr, b_wdata  in  1/1/AW/DW  port B request, same meaning as A
- b_gnt  out  1  port B granted
- b_rvalid  out  1  port B read data valid
- b_rdata  out  DW  port B read data
- mem_write_en  out  1  to mem_main write_en
- mem_address  out  AW  to mem_main address
- mem_write_data  out  DW  to mem_main write_data
- mem_data  in  DW  from mem_main data_out; valid one cycle after address

Behaviour:
- Reset (rst low, async): wait_cnt=0, rd_fsm=RD_NONE, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
  - Combinational outputs under reset: gnts=0, mem_write_en=0, mem_address=0, mem_write_data=0.
- Grant (combinational, same cycle as req):
  - halt_sys=1: no grant.
  - Else if a_req & b_req: b_gnt if wait_cnt==MAX_WAIT, otherwise a_gnt.
  - Else the sole requester is granted.
  - a_gnt and b_gnt are never both 1.
- Memory drive (combinational mux of the granted port):
  - mem_address, mem_write_data = granted port's addr/wdata.
  - mem_write_en = granted port's we.
  - No grant: mem_address=a_addr, mem_write_data=0, mem_write_en=0.
- wait_cnt (registered):
  - b_req & ~b_gnt & ~halt_sys: increment, saturate at MAX_WAIT.
  - b_gnt or ~b_req: clear to 0.
  - halt_sys: hold.
- Read return FSM, states RD_NONE / RD_A / RD_B, next state computed every cycle:
  - RD_A if a_gnt & ~a_we; RD_B if b_gnt & ~b_we; else RD_NONE.
  - In state RD_A: a_rvalid=1, a_rdata=mem_data (registered capture into a_rdata on the following edge is not used; rdata is mem_data passed through while rvalid is high).
  - In state RD_B: likewise b_rvalid and b_rdata.
  - rdata of a non-owning port holds its last value.
- Latency:
  - Read: grant cycle N, data valid cycle N+1.
  - Write: committed at the edge ending cycle N. No rvalid is generated.
- Back-to-back: one grant per cycle sustained, with interleaved owners allowed (A read at N, B read at N+1 → a_rvalid at N+1, b_rvalid at N+2).
- halt_sys asserted while RD_x is pending: the pending rvalid is still delivered, then the FSM goes to RD_NONE.
- Read/write to the same address in consecutive cycles: ordering follows grant order. No forwarding.
- Reset mid-read: pending rvalid is dropped.

Decomposition:
- types_pkg gains:
  - rd_owner_t enum {RD_NONE, RD_A, RD_B}
  - MEM_AW and MEM_DW constants.
- No sub-module: the grant logic, wait counter and FSM fit in one module. mem_main is instantiated by the parent, not by the arbiter.

Test Plan:
- Reset: rst=0 mid-stream with a read pending → all gnt/rvalid/mem_write_en=0 immediately; after release wait_cnt=0 and no rvalid.
- Solo reads:
  - A read addr 0x0010, mem holds 0xBEEF → a_gnt cycle N, a_rvalid=1 and a_rdata=0xBEEF at N+1, b_rvalid=0.
  - B read 0x0020 (=0x1234) → b_rdata=0x1234 at N+1.
- Contention / anti-starvation: a_req and b_req held high with MAX_WAIT=4 → A granted 4 cycles, B granted on the 5th, wait_cnt cleared, pattern repeats. b_gnt & a_gnt never both 1; a_stall=1 exactly on the B cycles.
- Write then read: A writes 0x5A5A to 0x0030 at N; B reads 0x0030 at N+1 → b_rdata=0x5A5A at N+2. mem_write_en high only at N.
- Halt: halt_sys=1 for 3 cycles with both requesting and an A read granted just before → a_rvalid still delivered; no grants during halt; wait_cnt unchanged; arbitration resumes from the same wait_cnt after halt.
- Interleave: A read, B read, A write on consecutive cycles → a_rvalid N+1, b_rvalid N+2, no rvalid N+3, correct owner data each cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the main-memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int MEM_AW = 16;
    localparam int MEM_DW = 16;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_A    = 2'd1,
        RD_B    = 2'd2
    } rd_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single main-memory port: fixed A priority,
// anti-starvation promotion of B, and one-cycle read-return routing.
//
// state   | meaning
// --------+------------------------------------------------------------
// RD_NONE | no read data returning this cycle
// RD_A    | mem_data this cycle belongs to port A (read granted last cycle)
// RD_B    | mem_data this cycle belongs to port B (read granted last cycle)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW       = MEM_AW,
    parameter int DW       = MEM_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          halt_sys,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_stall,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,

    output logic          mem_write_en,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_write_data,
    input  logic [DW-1:0] mem_data
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0]    wait_cnt_q, wait_cnt_d;
    rd_owner_t     rd_q, rd_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;

    // Reset gates the grants so nothing reaches memory while rst is low.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst && !halt_sys) begin
            if (a_req && b_req) begin
                if (wait_cnt_q == WAIT_MAX) b_gnt = 1'b1;
                else                        a_gnt = 1'b1;
            end else if (a_req) begin
                a_gnt = 1'b1;
            end else if (b_req) begin
                b_gnt = 1'b1;
            end
        end
    end

    assign a_stall = a_req & ~a_gnt;

    always_comb begin
        mem_write_en   = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        if (a_gnt) begin
            mem_write_en   = a_we;
            mem_address    = a_addr;
            mem_write_data = a_wdata;
        end else if (b_gnt) begin
            mem_write_en   = b_we;
            mem_address    = b_addr;
            mem_write_data = b_wdata;
        end else if (rst) begin
            mem_address    = a_addr;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!halt_sys) begin
            if (b_req && !b_gnt) begin
                if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 4'd1;
            end else begin
                wait_cnt_d = '0;
            end
        end
    end

    always_comb begin
        rd_d      = RD_NONE;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        if (a_gnt && !a_we)      rd_d = RD_A;
        else if (b_gnt && !b_we) rd_d = RD_B;
        // Keep the last delivered word so a non-owning port's rdata stays put.
        case (rd_q)
            RD_A:    a_rdata_d = mem_data;
            RD_B:    b_rdata_d = mem_data;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            rd_q       <= RD_NONE;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_q       <= rd_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a_rvalid = (rd_q == RD_A);
    assign b_rvalid = (rd_q == RD_B);
    assign a_rdata  = a_rvalid ? mem_data : a_rdata_q;
    assign b_rdata  = b_rvalid ? mem_data : b_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous memory model.
module tb_mem_port_arbiter;

    typedef struct {
        logic        halt, a_req, a_we;
        logic [15:0] a_addr, a_wdata;
        logic        b_req, b_we;
        logic [15:0] b_addr, b_wdata;
        logic [69:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        halt_sys = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [15:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
    logic        a_gnt, a_stall, a_rvalid, b_gnt, b_rvalid, mem_write_en;
    logic [15:0] a_rdata, b_rdata, mem_address, mem_write_data;
    logic [15:0] mem_data;
    logic        preload = 1'b1;
    logic [15:0] mem [0:255];

    int n_vec = 0;
    int n_err = 0;
    vec_t vt[$];

    mem_port_arbiter #(.AW(16), .DW(16), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .halt_sys(halt_sys),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_stall(a_stall), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_write_en(mem_write_en), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            mem[8'h00] <= 16'h0000;
            mem[8'h10] <= 16'hBEEF;
            mem[8'h20] <= 16'h1234;
        end else begin
            if (mem_write_en) mem[mem_address[7:0]] <= mem_write_data;
            mem_data <= mem[mem_address[7:0]];
        end
    end

    function automatic vec_t mk(
        input logic h, input logic ar, input logic aw, input logic [15:0] aa, input logic [15:0] ad,
        input logic br, input logic bw, input logic [15:0] ba, input logic [15:0] bd,
        input logic ag, input logic bg, input logic ast, input logic mwe,
        input logic [15:0] ma, input logic [15:0] md,
        input logic arv, input logic [15:0] ard, input logic brv, input logic [15:0] brd);
        vec_t v;
        v.halt = h; v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
        v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
        v.exp = {ag, bg, ast, mwe, ma, md, arv, ard, brv, brd};
        return v;
    endfunction

    function automatic logic [69:0] outs();
        return {a_gnt, b_gnt, a_stall, mem_write_en, mem_address, mem_write_data,
                a_rvalid, a_rdata, b_rvalid, b_rdata};
    endfunction

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        halt_sys = v.halt;
        a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata;
        b_req = v.b_req; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata;
    endtask

    task automatic set_in(input logic ar, input logic aw, input logic [15:0] aa,
                          input logic br, input logic bw, input logic [15:0] ba);
        halt_sys = 1'b0;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = '0;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = '0;
    endtask

    initial begin
        // Solo reads, write-then-read, contention, halt, interleave.
        vt.push_back(mk(0,0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000,16'h0000, 0,16'h0000,0,16'h0000));
        vt.push_back(mk(0,1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 1,0,0,0,16'h0010,16'h0000, 0,16'h0000,0,16'h0000));
        vt.push_back(mk(0,0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000,16'h0000, 1,16'hBEEF,0,16'h0000));
        vt.push_back(mk(0,0,0,16'h0000,16'h0000, 1,0,16'h0020,16'h0000, 0,1,0,0,16'h0020,16'h0000, 0,16'hBEEF,0,16'h0000));
        vt.push_back(mk(0,0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000,16'h0000, 0,16'hBEEF,1,16'h1234));
        vt.push_back(mk(0,1,1,16'h0030,16'h5A5A, 0,0,16'h0000,16'h0000, 1,0,0,1,16'h0030,16'h5A5A, 0,16'hBEEF,0,16'h1234));
        vt.push_back(mk(0,0,0,16'h0000,16'h0000, 1,0,16'h0030,16'h0000, 0,1,0,0,16'h0030,16'h0000, 0,16'hBEEF,0,16'h1234));
        vt.push_back(mk(0,0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000,16'h0000, 0,16'hBEEF,1,16'h5A5A));
        vt.push_back(mk(0,1,0,16'h0010,16'h0000, 1,0,16'h0020,16'h0000, 1,0,0,0,16'h0010,16'h0000, 0,16'hBEEF,0,16'h5A5A));
        for (int k = 0; k < 3; k++)
            vt.push_back(mk(0,1,0,16'h0010,16'h0000, 1,0,16'h0020,16'h0000, 1,0,0,0,16'h0010,16'h0000, 1,16'hBEEF,0,16'h5A5A));
        vt.push_back(mk(0,1,0,16'h0010,16'h0000, 1,0,16'h0020,16'h0000, 0,1,1,0,16'h0020,16'h0000, 1,16'hBEEF,0,16'h5A5A));
        vt.push_back(mk(0,1,0,16'h0010,16'h0000, 1,0,16'h0020,16'h0000, 1,0,0,0,16'h0010,16'h0000, 0,16'hBEEF,1,16'h1234));
        for (int k = 0; k < 3; k++)
            vt.push_back(mk(0,1,0,16'h0010,16'h0000, 1,0,16'h0020,16'h0000, 1,0,0,0,16'h0010,16'h0000, 1,16'hBEEF,0,16'h1234));
        vt.push_back(mk(0,1,0,16'h0010,16'h0000, 1,0,16'h0020,16'h0000, 0,1,1,0,16'h0020,16'h0000, 1,16'hBEEF,0,16'h1234));
        vt.push_back(mk(0,1,0,16'h0010,16'h0000, 1,0,16'h0020,16'h0000, 1,0,0,0,16'h0010,16'h0000, 0,16'hBEEF,1,16'h1234));
        vt.push_back(mk(0,1,0,16'h0010,16'h0000, 1,0,16'h0020,16'h0000, 1,0,0,0,16'h0010,16'h0000, 1,16'hBEEF,0,16'h1234));
        vt.push_back(mk(1,1,0,16'h0010,16'h0000, 1,0,16'h0020,16'h0000, 0,0,1,0,16'h0010,16'h0000, 1,16'hBEEF,0,16'h1234));
        for (int k = 0; k < 2; k++)
            vt.push_back(mk(1,1,0,16'h0010,16'h0000, 1,0,16'h0020,16'h0000, 0,0,1,0,16'h0010,16'h0000, 0,16'hBEEF,0,16'h1234));
        vt.push_back(mk(0,1,0,16'h0010,16'h0000, 1,0,16'h0020,16'h0000, 1,0,0,0,16'h0010,16'h0000, 0,16'hBEEF,0,16'h1234));
        vt.push_back(mk(0,1,0,16'h0010,16'h0000, 1,0,16'h0020,16'h0000, 1,0,0,0,16'h0010,16'h0000, 1,16'hBEEF,0,16'h1234));
        vt.push_back(mk(0,1,0,16'h0010,16'h0000, 1,0,16'h0020,16'h0000, 0,1,1,0,16'h0020,16'h0000, 1,16'hBEEF,0,16'h1234));
        vt.push_back(mk(0,1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 1,0,0,0,16'h0010,16'h0000, 0,16'hBEEF,1,16'h1234));
        vt.push_back(mk(0,0,0,16'h0000,16'h0000, 1,0,16'h0020,16'h0000, 0,1,0,0,16'h0020,16'h0000, 1,16'hBEEF,0,16'h1234));
        vt.push_back(mk(0,1,1,16'h0040,16'h7777, 0,0,16'h0000,16'h0000, 1,0,0,1,16'h0040,16'h7777, 0,16'hBEEF,1,16'h1234));
        vt.push_back(mk(0,0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000,16'h0000, 0,16'hBEEF,0,16'h1234));
        vt.push_back(mk(0,0,0,16'h0000,16'h0000, 1,1,16'h0050,16'h1111, 0,1,0,1,16'h0050,16'h1111, 0,16'hBEEF,0,16'h1234));
        vt.push_back(mk(0,1,0,16'h0040,16'h0000, 0,0,16'h0000,16'h0000, 1,0,0,0,16'h0040,16'h0000, 0,16'hBEEF,0,16'h1234));
        vt.push_back(mk(0,0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000,16'h0000, 1,16'h7777,0,16'h1234));
        vt.push_back(mk(0,0,0,16'h0000,16'h0000, 1,0,16'h0050,16'h0000, 0,1,0,0,16'h0050,16'h0000, 0,16'h7777,0,16'h1234));
        vt.push_back(mk(0,0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000,16'h0000, 0,16'h7777,1,16'h1111));

        repeat (3) @(posedge clk);
        preload = 1'b0;
        @(negedge clk);
        chk("reset_state", outs(), 70'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        foreach (vt[i]) begin
            if (i != 0) begin
                @(posedge clk); #1;
            end
            drive(vt[i]);
            @(negedge clk);
            chk($sformatf("row%0d", i), outs(), vt[i].exp);
            chk($sformatf("row%0d_gnt_excl", i), {69'b0, a_gnt & b_gnt}, 70'h0);
        end

        // Reset mid-read with a nonzero wait count.
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            set_in(1, 0, 16'h0010, 1, 0, 16'h0020);
            @(negedge clk);
            chk($sformatf("pre_rst_a_gnt%0d", k), {69'b0, a_gnt}, 70'h1);
        end
        @(posedge clk); #1;
        a_we = 1'b1;
        rst  = 1'b0;
        #1;
        chk("rst_async_outs", {a_gnt, b_gnt, a_rvalid, b_rvalid, mem_write_en, mem_address, mem_write_data, a_rdata, b_rdata},
            70'h0);
        @(posedge clk); #1;
        set_in(0, 0, 16'h0000, 0, 0, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", outs(), 70'h0);

        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            set_in(1, 0, 16'h0010, 1, 0, 16'h0020);
            @(negedge clk);
            chk($sformatf("post_rst_contend%0d", k), {68'b0, a_gnt, b_gnt},
                ((k % 5) == 4) ? 70'h1 : 70'h2);
        end

        @(posedge clk); #1;
        set_in(0, 0, 16'h0000, 0, 0, 16'h0000);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
